// File: rtl/fir_ntap_stream_if.sv
// Stream, coefficient-write and status signals of the N-tap FIR, grouped for port binding.
// The master side drives samples and coefficients; the slave side is the filter.
interface fir_ntap_stream_if #(
    parameter int NTAPS = 4,
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int OW    = 16
);
    logic                       in_valid;
    logic signed [DW-1:0]       x_in;
    logic                       flush;
    logic                       coef_we;
    logic [$clog2(NTAPS)-1:0]   coef_addr;
    logic signed [CW-1:0]       coef_data;
    logic signed [OW-1:0]       y_out;
    logic                       out_valid;
    logic                       sat_flag;
    logic                       primed;

    modport master (
        output in_valid, x_in, flush, coef_we, coef_addr, coef_data,
        input  y_out, out_valid, sat_flag, primed
    );

    modport slave (
        input  in_valid, x_in, flush, coef_we, coef_addr, coef_data,
        output y_out, out_valid, sat_flag, primed
    );
endinterface

// File: rtl/fir_ntap_stream.sv
// Direct-form N-tap FIR on a valid-qualified stream with a runtime-writable
// coefficient bank, saturating output, synchronous flush and a primed indicator.
module fir_ntap_stream #(
    parameter int NTAPS = 4,
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int OW    = 16
) (
    input  logic              clk,
    input  logic              rst,
    fir_ntap_stream_if.slave  io_bus
);
    localparam int AW     = DW + CW + $clog2(NTAPS);
    localparam int PW     = DW + CW;
    localparam int ADDR_W = $clog2(NTAPS);
    localparam int CNT_W  = $clog2(NTAPS + 1);

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    // Full-precision signed product, sign-extended to the accumulator width.
    function automatic logic signed [AW-1:0] mul_ext(input logic signed [DW-1:0] x,
                                                     input logic signed [CW-1:0] h);
        logic [PW-1:0] p;
        p = {{CW{x[DW-1]}}, x} * {{DW{h[CW-1]}}, h};
        return {{(AW-PW){p[PW-1]}}, p};
    endfunction

    // Returns {clipped, value}.
    function automatic logic [OW:0] saturate(input logic signed [AW-1:0] s);
        if (s > SAT_MAX)
            return {1'b1, SAT_MAX[OW-1:0]};
        else if (s < SAT_MIN)
            return {1'b1, SAT_MIN[OW-1:0]};
        else
            return {1'b0, s[OW-1:0]};
    endfunction

    logic signed [DW-1:0] r_tap [NTAPS-1];
    logic signed [CW-1:0] r_h   [NTAPS];
    logic signed [OW-1:0] r_y_p0;
    logic                 r_vld_p0;
    logic                 r_sat_p0;
    logic [CNT_W-1:0]     r_cnt;

    logic signed [AW-1:0] w_sum;
    logic [OW:0]          w_sat;
    logic                 w_coef_wr;

    assign w_coef_wr = io_bus.coef_we &&
                       ({1'b0, io_bus.coef_addr} < (ADDR_W+1)'(NTAPS));

    // x_in is x[n]; r_tap[k-1] holds x[n-k] before this edge's shift.
    always_comb begin
        w_sum = mul_ext(io_bus.x_in, r_h[0]);
        for (int k = 1; k < NTAPS; k++)
            w_sum = w_sum + mul_ext(r_tap[k-1], r_h[k]);
    end

    assign w_sat = saturate(w_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++)
                r_h[k] <= '0;
        end else if (w_coef_wr) begin
            r_h[io_bus.coef_addr] <= io_bus.coef_data;
        end
    end

    // Stage p0: delay line shift and registered, saturated output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTAPS-1; k++)
                r_tap[k] <= '0;
            r_y_p0   <= '0;
            r_vld_p0 <= 1'b0;
            r_sat_p0 <= 1'b0;
            r_cnt    <= '0;
        end else if (io_bus.flush) begin
            for (int k = 0; k < NTAPS-1; k++)
                r_tap[k] <= '0;
            r_y_p0   <= '0;
            r_vld_p0 <= 1'b0;
            r_sat_p0 <= 1'b0;
            r_cnt    <= '0;
        end else if (io_bus.in_valid) begin
            r_tap[0] <= io_bus.x_in;
            for (int k = 1; k < NTAPS-1; k++)
                r_tap[k] <= r_tap[k-1];
            r_y_p0   <= w_sat[OW-1:0];
            r_sat_p0 <= w_sat[OW];
            r_vld_p0 <= 1'b1;
            if (r_cnt != CNT_W'(NTAPS))
                r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_vld_p0 <= 1'b0;
        end
    end

    assign io_bus.y_out     = r_y_p0;
    assign io_bus.out_valid = r_vld_p0;
    assign io_bus.sat_flag  = r_sat_p0;
    assign io_bus.primed    = (r_cnt == CNT_W'(NTAPS));
endmodule

// File: tb/tb_fir_ntap_stream.sv
// Directed, scoreboard-based bench for fir_ntap_stream (4-tap main instance,
// plus a 3-tap instance where an out-of-range coefficient address is encodable).
module tb_fir_ntap_stream;
    localparam int NT   = 4;
    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int OW   = 16;
    localparam int AWD  = $clog2(NT);
    localparam int YMAX = 32767;
    localparam int YMIN = -32768;

    typedef struct {
        int   y;
        logic sat;
        logic primed;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_ntap_stream_if #(.NTAPS(NT), .DW(DW), .CW(CW), .OW(OW)) u_if ();
    fir_ntap_stream_if #(.NTAPS(3),  .DW(DW), .CW(CW), .OW(OW)) u_if3 ();

    fir_ntap_stream #(.NTAPS(NT), .DW(DW), .CW(CW), .OW(OW)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (u_if)
    );

    fir_ntap_stream #(.NTAPS(3), .DW(DW), .CW(CW), .OW(OW)) dut3 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (u_if3)
    );

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mh[NT];
    int   hist[NT-1];
    int   mcnt;
    int   last_y;
    logic last_sat;
    int   x3[4] = '{5, 6, 7, 8};
    int   y3[4] = '{5, 16, 34, 40};

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        foreach (mh[i]) mh[i] = 0;
        foreach (hist[i]) hist[i] = 0;
        mcnt     = 0;
        last_y   = 0;
        last_sat = 1'b0;
        sb_q.delete();
    endtask

    // One clock: drive on negedge, advance the model, check 1 ns after posedge.
    task automatic cycle(input string nm, input logic vld, input int x, input logic fl,
                         input logic we, input int addr, input int data);
        exp_t e;
        int   acc;
        @(negedge clk);
        u_if.in_valid  = vld;
        u_if.x_in      = DW'(x);
        u_if.flush     = fl;
        u_if.coef_we   = we;
        u_if.coef_addr = AWD'(addr);
        u_if.coef_data = CW'(data);
        if (fl) begin
            foreach (hist[i]) hist[i] = 0;
            mcnt     = 0;
            last_y   = 0;
            last_sat = 1'b0;
        end else if (vld) begin
            acc = mh[0] * x;
            for (int k = 1; k < NT; k++)
                acc += mh[k] * hist[k-1];
            if (acc > YMAX) begin
                e.y = YMAX; e.sat = 1'b1;
            end else if (acc < YMIN) begin
                e.y = YMIN; e.sat = 1'b1;
            end else begin
                e.y = acc;  e.sat = 1'b0;
            end
            for (int k = NT-2; k > 0; k--)
                hist[k] = hist[k-1];
            hist[0] = x;
            if (mcnt < NT) mcnt++;
            e.primed = (mcnt == NT);
            sb_q.push_back(e);
            last_y   = e.y;
            last_sat = e.sat;
        end
        if (we && addr < NT) mh[addr] = data;
        @(posedge clk);
        #1;
        if (fl) begin
            chk({nm, "/flush_y"},      u_if.y_out,     0);
            chk({nm, "/flush_vld"},    u_if.out_valid, 0);
            chk({nm, "/flush_sat"},    u_if.sat_flag,  0);
            chk({nm, "/flush_primed"}, u_if.primed,    0);
        end else if (vld) begin
            e = sb_q.pop_front();
            chk({nm, "/y"},      u_if.y_out,     e.y);
            chk({nm, "/vld"},    u_if.out_valid, 1);
            chk({nm, "/sat"},    u_if.sat_flag,  e.sat);
            chk({nm, "/primed"}, u_if.primed,    e.primed);
        end else begin
            chk({nm, "/idle_vld"}, u_if.out_valid, 0);
            chk({nm, "/idle_y"},   u_if.y_out,     last_y);
            chk({nm, "/idle_sat"}, u_if.sat_flag,  last_sat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        u_if.in_valid = 1'b0;  u_if.x_in = '0;  u_if.flush = 1'b0;
        u_if.coef_we  = 1'b0;  u_if.coef_addr = '0;  u_if.coef_data = '0;
        u_if3.in_valid = 1'b0; u_if3.x_in = '0; u_if3.flush = 1'b0;
        u_if3.coef_we  = 1'b0; u_if3.coef_addr = '0; u_if3.coef_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst/y",      u_if.y_out,     0);
        chk("rst/vld",    u_if.out_valid, 0);
        chk("rst/sat",    u_if.sat_flag,  0);
        chk("rst/primed", u_if.primed,    0);
        @(negedge clk);
        rst = 1'b0;

        // Scenario 1: h=1,2,3,4; x=5,6,7,8,0 -> 5,16,34,60,61
        for (int k = 0; k < NT; k++) cycle("s1wr", 0, 0, 0, 1, k, k + 1);
        cycle("s1x5", 1, 5, 0, 0, 0, 0);
        cycle("s1x6", 1, 6, 0, 0, 0, 0);
        cycle("s1x7", 1, 7, 0, 0, 0, 0);
        cycle("s1x8", 1, 8, 0, 0, 0, 0);
        cycle("s1x0", 1, 0, 0, 0, 0, 0);

        // Scenario 2: gap of idle cycles holds y
        cycle("s2fl", 0, 0, 1, 0, 0, 0);
        cycle("s2x5", 1, 5, 0, 0, 0, 0);
        repeat (3) cycle("s2gap", 0, 0, 0, 0, 0, 0);
        cycle("s2x6", 1, 6, 0, 0, 0, 0);

        // Scenario 3: positive then negative saturation
        for (int k = 0; k < NT; k++) cycle("s3wr", 0, 0, (k == 0), 1, k, 127);
        repeat (4) cycle("s3pos", 1, 127, 0, 0, 0, 0);
        cycle("s3fl", 0, 0, 1, 0, 0, 0);
        repeat (4) cycle("s3neg", 1, -128, 0, 0, 0, 0);

        // Scenario 4: coefficient write on the same edge as a sample
        for (int k = 0; k < NT; k++) cycle("s4wr", 0, 0, (k == 0), 1, k, k + 1);
        cycle("s4x5", 1, 5, 0, 0, 0, 0);
        cycle("s4x6", 1, 6, 0, 0, 0, 0);
        cycle("s4x7w", 1, 7, 0, 1, 0, 10);
        cycle("s4x8", 1, 8, 0, 0, 0, 0);

        // Scenario 5: flush wins over a simultaneous sample
        cycle("s5wr", 0, 0, 1, 1, 0, 1);
        cycle("s5x5", 1, 5, 0, 0, 0, 0);
        cycle("s5x6", 1, 6, 0, 0, 0, 0);
        cycle("s5x7", 1, 7, 0, 0, 0, 0);
        cycle("s5fl9", 1, 9, 1, 0, 0, 0);
        cycle("s5x1", 1, 1, 0, 0, 0, 0);

        // Scenario 6: asynchronous reset mid-stream clears everything before the next edge
        cycle("s6fl", 0, 0, 1, 0, 0, 0);
        cycle("s6x5", 1, 5, 0, 0, 0, 0);
        cycle("s6x6", 1, 6, 0, 0, 0, 0);
        cycle("s6x7", 1, 7, 0, 0, 0, 0);
        cycle("s6x8", 1, 8, 0, 0, 0, 0);
        #2;
        u_if.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst/y",      u_if.y_out,     0);
        chk("arst/vld",    u_if.out_valid, 0);
        chk("arst/sat",    u_if.sat_flag,  0);
        chk("arst/primed", u_if.primed,    0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle("s6post", 1, 5, 0, 0, 0, 0);

        // 3-tap instance: address 3 is out of range and must be ignored
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            u_if3.coef_we   = 1'b1;
            u_if3.coef_addr = 2'(k);
            u_if3.coef_data = (k == 3) ? CW'(99) : CW'(k + 1);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            u_if3.coef_we  = 1'b0;
            u_if3.in_valid = 1'b1;
            u_if3.x_in     = DW'(x3[i]);
            @(posedge clk);
            #1;
            chk($sformatf("n3/y%0d", i), u_if3.y_out, y3[i]);
        end
        @(negedge clk);
        u_if3.in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
